// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator: sums blocks of NUM_SAMPLES adder results and presents total/min/max/overflow per block
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   clear               : synchronous abort of the current block, back to IDLE
//   in_valid/in_ready   : handshake for in_data (unsigned IN_W-bit sum)
//   out_valid/out_ready : handshake for the result beat, held until accepted
//   out_sum             : saturating block total (ACC_W bits)
//   out_min/out_max     : smallest/largest sum seen in the block
//   out_ovf             : total saturated at some point in the block
//   sample_cnt          : sums accepted so far in the current block
module sum_block_accumulator #(
    parameter int IN_W        = 33,
    parameter int ACC_W       = 40,
    parameter int NUM_SAMPLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [IN_W-1:0]  out_min,
    output logic [IN_W-1:0]  out_max,
    output logic             out_ovf,
    output logic [CNT_W-1:0] sample_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [ACC_W:0]   sum_w;
    logic [IN_W-1:0]  mn, mx, mn_nx, mx_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf, sat, accept, last, restart;
    // ready/valid are pure state decodes; rst_n gating keeps in_ready low during reset
    assign in_ready  = rst_n && (state != DONE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    // one extra bit captures the carry out of the accumulator
    assign sum_w   = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    assign sat     = sum_w[ACC_W] || ovf;
    assign acc_nx  = sat ? '1 : sum_w[ACC_W-1:0];
    assign mn_nx   = (in_data < mn) ? in_data : mn;
    assign mx_nx   = (in_data > mx) ? in_data : mx;
    assign cnt_inc = sample_cnt + 1'b1;
    assign last    = (cnt_inc == CNT_W'(NUM_SAMPLES));
    // accumulators re-initialise on abort or when the result beat is taken
    assign restart = clear || (out_valid && out_ready);
    always_comb begin
        state_nx = state;
        if (clear)
            state_nx = IDLE;
        else if (state == DONE)
            state_nx = out_ready ? IDLE : DONE;
        else if (accept)
            state_nx = last ? DONE : ACCUM;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            mn         <= '1;
            mx         <= '0;
            ovf        <= 1'b0;
            sample_cnt <= '0;
            out_sum    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state <= state_nx;
            if (restart) begin
                acc        <= '0;
                mn         <= '1;
                mx         <= '0;
                ovf        <= 1'b0;
                sample_cnt <= '0;
            end else if (accept) begin
                acc        <= acc_nx;
                mn         <= mn_nx;
                mx         <= mx_nx;
                ovf        <= sat;
                sample_cnt <= cnt_inc;
                // the result registers include the closing sample's contribution
                if (last) begin
                    out_sum <= acc_nx;
                    out_min <= mn_nx;
                    out_max <= mx_nx;
                    out_ovf <= sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_sum_block_accumulator.sv
// tb_sum_block_accumulator: directed scoreboard bench for three parameterisations of sum_block_accumulator
module tb_sum_block_accumulator;
    typedef struct {
        int          tag;
        logic [39:0] sum;
        logic [32:0] mn;
        logic [32:0] mx;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [32:0] in_data [3];
    logic        o_valid [3];
    logic        out_ready [3];
    logic [39:0] o_sum [3];
    logic [32:0] o_min [3];
    logic [32:0] o_max [3];
    logic        o_ovf [3];
    logic [7:0]  cnt [3];
    logic [32:0] o_sum1;

    exp_t            q[$];
    longint unsigned blk[$];
    int              n_tests = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    sum_block_accumulator dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(o_valid[0]), .out_ready(out_ready[0]), .out_sum(o_sum[0]),
        .out_min(o_min[0]), .out_max(o_max[0]), .out_ovf(o_ovf[0]), .sample_cnt(cnt[0])
    );

    sum_block_accumulator #(.ACC_W(33), .NUM_SAMPLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(o_valid[1]), .out_ready(out_ready[1]), .out_sum(o_sum1),
        .out_min(o_min[1]), .out_max(o_max[1]), .out_ovf(o_ovf[1]), .sample_cnt(cnt[1])
    );
    assign o_sum[1] = {7'd0, o_sum1};

    sum_block_accumulator #(.NUM_SAMPLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(o_valid[2]), .out_ready(out_ready[2]), .out_sum(o_sum[2]),
        .out_min(o_min[2]), .out_max(o_max[2]), .out_ovf(o_ovf[2]), .sample_cnt(cnt[2])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", name, got, exp);
        end
    endtask

    // reference model: saturating sum plus unsigned min/max over the queued block
    task automatic push_exp(input int k, input int accw);
        exp_t            e;
        longint unsigned s = 0;
        longint unsigned lim = (64'd1 << accw) - 1;
        e.tag = k;
        e.mn  = '1;
        e.mx  = '0;
        e.ovf = 1'b0;
        foreach (blk[i]) begin
            s = s + blk[i];
            if (e.ovf || s > lim) begin
                s     = lim;
                e.ovf = 1'b1;
            end
            if (33'(blk[i]) < e.mn) e.mn = 33'(blk[i]);
            if (33'(blk[i]) > e.mx) e.mx = 33'(blk[i]);
        end
        e.sum = 40'(s);
        q.push_back(e);
    endtask

    task automatic send(input int k, input longint unsigned v);
        in_valid[k] = 1'b1;
        in_data[k]  = 33'(v);
        for (int i = 0; i < 50; i++) begin
            if (in_ready[k]) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $error("FAIL send_timeout observed=in_ready_low expected=accept");
    endtask

    task automatic send_blk(input int k, input bit gap);
        foreach (blk[i]) begin
            send(k, blk[i]);
            if (gap && i != blk.size() - 1) begin
                in_valid[k] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && o_valid[k] && out_ready[k]) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(k), 64'd99);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("beat_inst", 64'(k), 64'(e.tag));
                    chk("beat_sum", 64'(o_sum[k]), 64'(e.sum));
                    chk("beat_min", 64'(o_min[k]), 64'(e.mn));
                    chk("beat_max", 64'(o_max[k]), 64'(e.mx));
                    chk("beat_ovf", 64'(o_ovf[k]), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        #3;
        chk("rst_out_valid", 64'(o_valid[0]), 64'd0);
        chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("rst_out_sum", 64'(o_sum[0]), 64'd0);
        chk("rst_cnt", 64'(cnt[0]), 64'd0);
        #4 rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready[0]), 64'd1);

        // block 1: back-to-back, consumer always ready
        blk = '{290, 269, 327, 244, 298, 250, 294, 292, 344, 323};
        push_exp(0, 40);
        send_blk(0, 1'b0);
        chk("t1_latency_valid", 64'(o_valid[0]), 64'd1);
        chk("t1_done_cnt", 64'(cnt[0]), 64'd10);
        tick();
        chk("t1_valid_one_cycle", 64'(o_valid[0]), 64'd0);
        chk("t1_idle_ready", 64'(in_ready[0]), 64'd1);

        // block 2: gapped input, stalled consumer
        out_ready[0] = 1'b0;
        push_exp(0, 40);
        send_blk(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_valid", 64'(o_valid[0]), 64'd1);
            chk("t2_stall_ready", 64'(in_ready[0]), 64'd0);
            chk("t2_stall_sum", 64'(o_sum[0]), 64'd2931);
            chk("t2_stall_min", 64'(o_min[0]), 64'd244);
            chk("t2_stall_max", 64'(o_max[0]), 64'd344);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        chk("t2_released", 64'(o_valid[0]), 64'd0);
        blk = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
        push_exp(0, 40);
        send_blk(0, 1'b0);
        tick();

        // saturation on a 33-bit accumulator, then recovery
        blk = '{64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF};
        push_exp(1, 33);
        send_blk(1, 1'b0);
        tick();
        blk = '{1, 2};
        push_exp(1, 33);
        send_blk(1, 1'b0);
        tick();

        // clear after four accepts; a sum presented with clear is dropped
        blk = '{10, 20, 30, 40};
        send_blk(0, 1'b0);
        chk("t4_cnt_before", 64'(cnt[0]), 64'd4);
        clear = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0] = 33'd999;
        tick();
        clear = 1'b0;
        in_valid[0] = 1'b0;
        chk("t4_cnt_cleared", 64'(cnt[0]), 64'd0);
        chk("t4_ready", 64'(in_ready[0]), 64'd1);
        chk("t4_no_valid", 64'(o_valid[0]), 64'd0);
        blk = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50};
        push_exp(0, 40);
        send_blk(0, 1'b0);
        tick();

        // asynchronous reset while a result is pending
        out_ready[0] = 1'b0;
        blk = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        send_blk(0, 1'b0);
        chk("t5_pending", 64'(o_valid[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_drop", 64'(o_valid[0]), 64'd0);
        chk("t5_sum_zero", 64'(o_sum[0]), 64'd0);
        chk("t5_min_zero", 64'(o_min[0]), 64'd0);
        chk("t5_max_zero", 64'(o_max[0]), 64'd0);
        chk("t5_ovf_zero", 64'(o_ovf[0]), 64'd0);
        chk("t5_cnt_zero", 64'(cnt[0]), 64'd0);
        chk("t5_ready_low", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        blk = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        push_exp(0, 40);
        send_blk(0, 1'b0);
        tick();

        // single-sample blocks
        blk = '{7};
        push_exp(2, 40);
        send_blk(2, 1'b0);
        chk("t6_valid", 64'(o_valid[2]), 64'd1);
        blk = '{9};
        push_exp(2, 40);
        send_blk(2, 1'b0);
        tick();
        tick();

        chk("beats_left", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
